// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle control FSM (optional MC_ILLEGAL_TRAP_EN adds TRAP state and illegal port)
// State register only; every output is decoded combinationally from state and instruction fields.
module multicycle_ctrl (
  input  logic       Clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t state;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            7'b0000011, 7'b0100011: state <= MEMADR;
            7'b0110011:             state <= EXECUTER;
            7'b0010011:             state <= EXECUTEI;
            7'b1100011:             state <= BEQ;
            7'b1101111:             state <= JAL;
`ifdef MC_ILLEGAL_TRAP_EN
            default:                state <= TRAP;
`else
            default:                state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
        TRAP:     state <= TRAP;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  logic [1:0] aluop;
  logic       ir_raw, pc_raw, rw_raw, mw_raw;

  always_comb begin
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    adrsrc    = 1'b0;
    aluop     = 2'b00;
    ir_raw    = 1'b0;
    pc_raw    = 1'b0;
    rw_raw    = 1'b0;
    mw_raw    = 1'b0;
    case (state)
      FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        ir_raw    = mem_ready;
        pc_raw    = mem_ready;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        rw_raw    = 1'b1;
      end
      MEMWRITE: begin
        adrsrc = 1'b1;
        mw_raw = 1'b1;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB:    rw_raw = 1'b1;
      BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pc_raw  = zero;
      end
      JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pc_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing writes in the cycle reset falls.
  assign irwrite  = ir_raw & reset;
  assign pcwrite  = pc_raw & reset;
  assign regwrite = rw_raw & reset;
  assign memwrite = mw_raw & reset;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal  = (state == TRAP) & reset;
`endif

  always_comb begin
    case (op)
      7'b0100011: immsrc = 2'b01;
      7'b1100011: immsrc = 2'b10;
      7'b1101111: immsrc = 2'b11;
      default:    immsrc = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
// Outputs are packed as {immsrc,alusrca,alusrcb,resultsrc,adrsrc,alucontrol,irwrite,pcwrite,regwrite,memwrite}.
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite;
  logic [2:0] alucontrol;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .Clk(Clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .immsrc(immsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .resultsrc(resultsrc), .adrsrc(adrsrc),
    .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 Clk = ~Clk;

  wire [15:0] obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                     irwrite, pcwrite, regwrite, memwrite};

  function automatic logic [15:0] sig(input logic [1:0] imm, input logic [1:0] asa,
                                      input logic [1:0] asb, input logic [1:0] rs,
                                      input logic adr, input logic [2:0] alu,
                                      input logic ir, input logic pc,
                                      input logic rw, input logic mw);
    return {imm, asa, asb, rs, adr, alu, ir, pc, rw, mw};
  endfunction

  task automatic test_reset;
    reset = 1'b0; mem_ready = 1'b1; op = 7'd0;
    @(negedge Clk); #1;
    checks++;
    if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_held: got %h expected %h", obs,
                         sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
`ifdef MC_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
`endif
    reset = 1'b1; #1;
    checks++;
    if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_release_fetch: got %h expected %h", obs,
                         sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_lw;
    logic [15:0] exp_v [5];
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    exp_v[0] = sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v[1] = sig(2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[2] = sig(2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[3] = sig(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[4] = sig(2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL lw_cycle%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_sw;
    logic [15:0] exp_v [7];
    logic        mr [7];
    int writes = 0, mw_cycles = 0, ir_cycles = 0;
    op = 7'b0100011; funct3 = 3'b010;
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_v[0] = sig(2'd1, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[1] = sig(2'd1, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v[2] = sig(2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[3] = sig(2'd1, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i < 7; i++)
      exp_v[i] = sig(2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1; checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL sw_cycle%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (memwrite) mw_cycles++;
      if (memwrite && mem_ready) writes++;
      if (irwrite) ir_cycles++;
      @(negedge Clk);
    end
    mem_ready = 1'b1;
    checks++;
    if (mw_cycles != 3) begin errors++; $display("FAIL sw_memwrite_cycles: got %0d expected 3", mw_cycles); end
    checks++;
    if (writes != 1) begin errors++; $display("FAIL sw_writes_done: got %0d expected 1", writes); end
    checks++;
    if (ir_cycles != 1) begin errors++; $display("FAIL sw_irwrite_count: got %0d expected 1", ir_cycles); end
  endtask

  task automatic test_beq;
    logic [15:0] exp_v [3];
    op = 7'b1100011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      zero = (pass == 0);
      exp_v[0] = sig(2'd2, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_v[1] = sig(2'd2, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v[2] = sig(2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0, zero, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        #1; checks++;
        if (obs !== exp_v[i]) begin
          errors++; $display("FAIL beq_z%0b_cycle%0d: got %h expected %h", zero, i, obs, exp_v[i]);
        end
        @(negedge Clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype;
    logic [2:0] f3 [3] = '{3'b000, 3'b010, 3'b111};
    logic [2:0] alu [3] = '{3'b001, 3'b101, 3'b010};
    logic [15:0] exp_v [4];
    op = 7'b0110011; funct7b5 = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      funct3 = f3[k];
      exp_v[0] = sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_v[1] = sig(2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v[2] = sig(2'd0, 2'd2, 2'd0, 2'd0, 1'b0, alu[k], 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v[3] = sig(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
        #1; checks++;
        if (obs !== exp_v[i]) begin
          errors++; $display("FAIL rtype_f3_%0d_cycle%0d: got %h expected %h", f3[k], i, obs, exp_v[i]);
        end
        @(negedge Clk);
      end
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_v [8];
    logic [6:0]  ops [8];
    mem_ready = 1'b1; funct3 = 3'b000; funct7b5 = 1'b1;
    // addi with funct7b5 set must still add; then jal immediately after.
    ops = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
            7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
    exp_v[0] = sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v[1] = sig(2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[2] = sig(2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[3] = sig(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_v[4] = sig(2'd3, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v[5] = sig(2'd3, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v[6] = sig(2'd3, 2'd1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_v[7] = sig(2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op = ops[i]; #1; checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(negedge Clk);
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_reset_mid;
    op = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 resets inside EXECUTER, pass 1 inside ALUWB while regwrite is high
      for (int i = 0; i < 2 + pass; i++) @(negedge Clk);
      #1; checks++;
      if (regwrite !== (pass == 1)) begin
        errors++; $display("FAIL rmid%0d_prestate_regwrite: got %b expected %b", pass, regwrite, pass == 1);
      end
      reset = 1'b0; #1; checks++;
      if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL rmid%0d_asserted: got %h expected %h", pass, obs,
                           sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      @(negedge Clk);
      reset = 1'b1; #1; checks++;
      if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
        errors++; $display("FAIL rmid%0d_release: got %h expected %h", pass, obs,
                           sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_illegal;
    op = 7'b1111111; mem_ready = 1'b1;
    #1; checks++;
    if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
      errors++; $display("FAIL illegal_fetch: got %h", obs);
    end
    @(negedge Clk); #1; checks++;
    if (obs !== sig(2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL illegal_decode: got %h", obs);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1; checks++;
      if (obs !== 16'h0000 || illegal !== 1'b1) begin
        errors++; $display("FAIL trap_cycle%0d: got %h illegal=%b expected 0000 illegal=1", i, obs, illegal);
      end
    end
    reset = 1'b0; #1; checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL trap_reset_illegal: got %b expected 0", illegal); end
    @(negedge Clk); reset = 1'b1; #1;
`else
    @(negedge Clk); #1;
`endif
    checks++;
    if (obs !== sig(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
      errors++; $display("FAIL illegal_back_to_fetch: got %h", obs);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_rtype();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
